bob_except_ctrl: RTL and testbench

BOB_EXCEPT_CTRL -- requirements
Module: bob_except_ctrl

---
 rtl/bob_except_ctrl.sv | 103 ++++++++++
 tb/tb_bob_except_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bob_except_ctrl.sv
// Exception-tracking controller for the branch-order buffer: allocates 10-slot rows,
// retires the oldest row through a one-cycle store read, and holds the first exception found.
module bob_except_ctrl #(
  parameter int ROWS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_rdy,
  output logic       alloc_wen,
  output logic [5:0] alloc_addr,
  input  logic       retire_req,
  output logic       read_step,
  output logic [5:0] read_addr,
  input  logic [9:0] row_exc,
  output logic       retire_vld,
  output logic       exc_found,
  output logic [5:0] exc_row,
  output logic [3:0] exc_slot,
  input  logic       flush,
  output logic [5:0] count,
  output logic [1:0] state_dbg
);

  // Handshake: a row is written in any cycle where alloc_req and alloc_rdy are both high;
  // alloc_req may rise or fall at will, and nothing is written in a cycle without both.
  localparam logic [5:0] ROWS_V = 6'(ROWS);
  localparam logic [5:0] LAST   = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] head, tail;
  logic       clr, adv, hit;

  function automatic logic [3:0] lowest_slot(input logic [9:0] v);
    lowest_slot = '0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) lowest_slot = 4'(i);
    end
  endfunction

  assign clr        = rst | flush;
  assign alloc_addr = tail;
  assign read_addr  = head;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (read_step) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = (row_exc == '0) ? S_IDLE : S_HOLD;
      S_HOLD:  state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
    if (clr) state_nxt = S_IDLE;
  end

  // No bypass: a full store refuses allocation even when a row retires this cycle.
  always_comb begin
    alloc_rdy  = (count < ROWS_V) && (state != S_HOLD) && !flush && !rst;
    alloc_wen  = alloc_req && alloc_rdy;
    read_step  = (state == S_IDLE) && retire_req && (count != '0) && !clr;
    retire_vld = (state == S_WAIT) && !rst;
    adv        = (state == S_WAIT) && (row_exc == '0) && !clr;
    hit        = (state == S_WAIT) && (row_exc != '0) && !clr;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      exc_found <= 1'b0;
      exc_row   <= '0;
      exc_slot  <= '0;
    end else begin
      if (alloc_wen) tail <= (tail == LAST) ? 6'd0 : tail + 6'd1;
      if (adv)       head <= (head == LAST) ? 6'd0 : head + 6'd1;
      case ({alloc_wen, adv})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
      // The excepting row stays at the head so the handler can find it by exc_row.
      if (hit) begin
        exc_found <= 1'b1;
        exc_row   <= head;
        exc_slot  <= lowest_slot(row_exc);
      end
    end
  end

endmodule

// File: tb/tb_bob_except_ctrl.sv
// Bench for bob_except_ctrl: directed scenarios followed by biased random traffic,
// checked against a queue-of-rows reference model through an expected-value scoreboard.
module tb_bob_except_ctrl;
  localparam int ROWS = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       retire_req = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] row_exc = '0;
  logic       alloc_rdy, alloc_wen, read_step, retire_vld, exc_found;
  logic [5:0] alloc_addr, read_addr, exc_row, count;
  logic [3:0] exc_slot;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle outputs: {rdy, wen, rstep, rvld, found, count[5:0], row[5:0], slot[3:0]}
  logic [20:0] exp_q[$];
  int          alloc_q[$];
  int          read_q[$];

  // Reference model: occupied rows as a FIFO of row indices, oldest at the front.
  int occ_q[$];
  int m_tail = 0;
  bit m_wait = 0, m_hold = 0, m_found = 0;
  int m_erow = 0, m_eslot = 0;

  bob_except_ctrl #(.ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_rdy(alloc_rdy),
    .alloc_wen(alloc_wen), .alloc_addr(alloc_addr), .retire_req(retire_req),
    .read_step(read_step), .read_addr(read_addr), .row_exc(row_exc),
    .retire_vld(retire_vld), .exc_found(exc_found), .exc_row(exc_row),
    .exc_slot(exc_slot), .flush(flush), .count(count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Drive one cycle of inputs, record what the DUT must show, then advance the model.
  task automatic step(input logic r, input logic f, input logic a, input logic q,
                      input logic [9:0] e);
    int   n;
    logic e_rdy, e_wen, e_rstep, e_rvld;
    @(negedge clk);
    rst = r; flush = f; alloc_req = a; retire_req = q; row_exc = e;
    #1;
    n       = occ_q.size();
    e_rdy   = !r && !f && !m_hold && (n < ROWS);
    e_wen   = a && e_rdy;
    e_rstep = !r && !f && !m_wait && !m_hold && q && (n != 0);
    e_rvld  = m_wait && !r;
    exp_q.push_back({e_rdy, e_wen, e_rstep, e_rvld, m_found, 6'(n), 6'(m_erow), 4'(m_eslot)});
    if (e_wen)   alloc_q.push_back(m_tail);
    if (e_rstep) read_q.push_back(occ_q[0]);
    if (r || f) begin
      occ_q.delete();
      m_tail = 0; m_wait = 0; m_hold = 0;
      m_found = 0; m_erow = 0; m_eslot = 0;
    end else begin
      if (m_wait && e != '0) begin
        m_hold = 1; m_found = 1; m_erow = occ_q[0]; m_eslot = first_set(e);
      end else if (m_wait) begin
        void'(occ_q.pop_front());
      end
      if (e_wen) begin
        occ_q.push_back(m_tail);
        m_tail = (m_tail + 1) % ROWS;
      end
      m_wait = e_rstep;
    end
  endtask

  task automatic retire_row(input logic [9:0] e);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, e);
  endtask

  // Monitor: pops and compares whenever the DUT presents outputs.
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("alloc_rdy",  alloc_rdy,  e[20]);
        chk("alloc_wen",  alloc_wen,  e[19]);
        chk("read_step",  read_step,  e[18]);
        chk("retire_vld", retire_vld, e[17]);
        chk("exc_found",  exc_found,  e[16]);
        chk("count",      count,      e[15:10]);
        chk("exc_row",    exc_row,    e[9:4]);
        chk("exc_slot",   exc_slot,   e[3:0]);
      end
      if (alloc_wen) begin
        if (alloc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL alloc_unexpected: got alloc_wen=1 at addr %0d, required none", alloc_addr);
        end else chk("alloc_addr", alloc_addr, alloc_q.pop_front());
      end
      if (read_step) begin
        if (read_q.size() == 0) begin
          total++; bad++;
          $display("FAIL read_unexpected: got read_step=1 at addr %0d, required none", read_addr);
        end else chk("read_addr", read_addr, read_q.pop_front());
      end
    end
  end

  initial begin
    int abias;
    logic r, f, a, q;
    logic [9:0] ev;
    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 1, '0);
    // Three allocs then a clean retire of row 0.
    repeat (3) step(0, 0, 1, 0, '0);
    retire_row('0);
    // Fill to capacity; tail passes 47 and wraps to 0.
    repeat (50) step(0, 0, 1, 0, '0);
    // Retire-advance with alloc_req while full: no alloc.
    step(0, 0, 0, 1, '0);
    step(0, 0, 1, 0, '0);
    // Retire until head wraps 47 -> 0.
    repeat (46) retire_row('0);
    retire_row('0);
    step(0, 1, 1, 1, '0);
    // Exception at head=5, lowest slot 2.
    repeat (8) step(0, 0, 1, 0, '0);
    repeat (5) retire_row('0);
    retire_row(10'b0000100100);
    repeat (3) step(0, 0, 1, 1, 10'($urandom_range(0, 1023)));
    step(0, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    // Reset arriving while a read is in flight.
    repeat (2) step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    step(1, 0, 0, 0, 10'b0000000001);
    step(0, 0, 0, 0, '0);
    // Biased random traffic.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       abias = 90;
        1:       abias = 50;
        default: abias = 15;
      endcase
      r  = ($urandom_range(0, 199) == 0);
      f  = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      a  = ($urandom_range(0, 99) < abias);
      q  = ($urandom_range(0, 99) < 60);
      ev = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
      step(r, f, a, q, ev);
    end
    @(negedge clk);
    rst = 1; flush = 0; alloc_req = 0; retire_req = 0; row_exc = '0;
    repeat (3) @(negedge clk);
    #5;
    total++;
    if (exp_q.size() + alloc_q.size() + read_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d unconsumed expectations, required 0",
               exp_q.size() + alloc_q.size() + read_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
